// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS unified-memory arbiter: FSM encoding,
// port ids and the load/store opcodes the pipeline decodes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2b;

endpackage

// File: rtl/mips_arb_starve_ctr.sv
// Saturating count of arbitrations the fetch port has lost in a row.
module mips_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == CW'(MAX));

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one fixed-latency single-port word memory between instruction fetch
// and the load/store port; one access in flight, registered one-cycle acks.
//   state    | meaning
//   ST_IDLE  | arbitrate, latch winner id, address, we and store data
//   ST_ISSUE | mem_en strobe for the latched access
//   ST_WAIT  | MEM_LAT-1 cycles until read data is valid
//   ST_DONE  | mem_rdata valid; captured, winner acked next cycle
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LAT    = 2,
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam int LAT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WAIT_LOAD = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;

  arb_state_e       state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             win_q;
  logic             if_cand, dm_cand, grant, grant_port;
  logic             starve_inc, starve_clr, starve_at_max;
  logic             unused_addr_bits;

  // A port whose ack is showing this cycle is still holding a stale request.
  assign if_cand = if_req & ~if_ack;
  assign dm_cand = dm_req & ~dm_ack;
  assign grant   = (state == ST_IDLE) & (if_cand | dm_cand);

  assign starve_inc = grant & if_cand & (grant_port == PORT_DM);
  assign starve_clr = grant & (grant_port == PORT_IF);

  mips_arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_max  (starve_at_max)
  );

  always_comb begin
    state_nxt  = state;
    grant_port = PORT_IF;
    if (dm_cand && !(if_cand && starve_at_max)) grant_port = PORT_DM;
    case (state)
      ST_IDLE:  if (grant) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lat_cnt   <= '0;
      win_q     <= PORT_IF;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            win_q <= grant_port;
            if (grant_port == PORT_DM) begin
              mem_addr <= dm_addr[AW+1:2];
              mem_we   <= dm_we;
              if (dm_we) mem_wdata <= dm_wdata;
            end else begin
              mem_addr <= if_addr[AW+1:2];
              mem_we   <= 1'b0;
            end
          end
        end
        ST_ISSUE: lat_cnt <= LAT_W'(WAIT_LOAD);
        ST_WAIT:  if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        ST_DONE: begin
          if (win_q == PORT_IF) begin
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
          end else begin
            if (!mem_we) dm_rdata <= mem_rdata;
            dm_ack <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == ST_ISSUE);
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = dm_req & ~dm_ack;

  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0], dm_addr[31:AW+2], dm_addr[1:0]};

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed latency/priority/reset cases, then
// random requesters checked every cycle against a transaction-level model.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, stall_if, stall_mem;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] env_mem [1024];
  logic [31:0] ref_mem [1024];
  int          cyc = 0;
  int          rd_due = -1;
  logic [31:0] rd_word = '0;
  int          total = 0;
  int          bad = 0;

  mips_mem_arbiter #(.MEM_LAT(LAT), .AW(10), .STARVE_MAX(SMAX)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memory: writes land in the mem_en cycle, read data is valid only LAT
  // cycles later and is random garbage in every other cycle.
  always @(negedge clock) begin
    if (mem_en === 1'b1) begin
      if (mem_we) env_mem[mem_addr] = mem_wdata;
      else begin
        rd_due  = cyc + LAT;
        rd_word = env_mem[mem_addr];
      end
    end
  end

  always @(posedge clock) begin
    #1;
    mem_rdata = (cyc == rd_due) ? rd_word : $urandom;
  end

  // Transaction-level reference: one access at a time, granted at cycle g,
  // mem_en at g+1, ack at g+2+LAT; the ack cycle is free for a new grant.
  initial begin : model
    bit          live, busy, post_rst, port, we, e_en, e_ia, e_da, if_c, dm_c, w_dm;
    int          g, starve;
    logic [9:0]  addr;
    logic [31:0] wdata, data, if_hold, a;
    live = 0; busy = 0; post_rst = 0; port = 0; we = 0;
    g = 0; starve = 0; addr = '0; wdata = '0; data = '0; if_hold = '0;
    forever begin
      @(negedge clock);
      e_en = busy && (cyc == g + 1);
      e_ia = busy && !port && (cyc == g + 2 + LAT);
      e_da = busy && port && (cyc == g + 2 + LAT);
      if (live) begin
        if (e_ia) if_hold = data;
        chk("mem_en", 32'(mem_en), 32'(e_en));
        chk("if_ack", 32'(if_ack), 32'(e_ia));
        chk("dm_ack", 32'(dm_ack), 32'(e_da));
        chk("stall_if", 32'(stall_if), 32'(if_req && !e_ia));
        chk("stall_mem", 32'(stall_mem), 32'(dm_req && !e_da));
        chk("if_rdata", if_rdata, if_hold);
        chk("starve_cnt", 32'(u_dut.u_starve.cnt), 32'(starve));
        if (e_en) begin
          chk("mem_addr", 32'(mem_addr), 32'(addr));
          chk("mem_we", 32'(mem_we), 32'(we));
          if (we) chk("mem_wdata", mem_wdata, wdata);
        end
        if (e_da && !we) chk("dm_rdata", dm_rdata, data);
        if (post_rst) begin
          chk("rst_mem_addr", 32'(mem_addr), 32'd0);
          chk("rst_mem_we", 32'(mem_we), 32'd0);
          chk("rst_mem_wdata", mem_wdata, 32'd0);
          chk("rst_dm_rdata", dm_rdata, 32'd0);
        end
      end
      if (e_ia || e_da) busy = 0;
      post_rst = 0;
      if (!reset_n) begin
        live = 1; busy = 0; starve = 0; if_hold = '0; post_rst = 1;
      end else if (live && !busy) begin
        if_c = if_req && !e_ia;
        dm_c = dm_req && !e_da;
        if (if_c || dm_c) begin
          w_dm = dm_c && !(if_c && starve == SMAX);
          if (w_dm && if_c && starve < SMAX) starve = starve + 1;
          if (!w_dm) starve = 0;
          busy  = 1;
          g     = cyc;
          port  = w_dm;
          a     = w_dm ? dm_addr : if_addr;
          addr  = a[11:2];
          we    = w_dm && dm_we;
          wdata = dm_wdata;
          data  = ref_mem[addr];
          if (we) ref_mem[addr] = dm_wdata;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Runs from the current cycle (k=0) until the port's ack, recording the
  // first mem_en cycle and whether stall was high exactly until the ack.
  task automatic wait_ack(input bit dm, input int budget, output int ack_at, output int en_at,
                          output logic [9:0] en_addr, output logic en_we, output bit stall_ok);
    ack_at = -1; en_at = -1; en_addr = '0; en_we = 1'b0; stall_ok = 1;
    for (int k = 0; k <= budget; k++) begin
      @(negedge clock);
      if (mem_en === 1'b1 && en_at < 0) begin
        en_at = k; en_addr = mem_addr; en_we = mem_we;
      end
      if ((dm ? dm_ack : if_ack) === 1'b1) begin
        ack_at = k;
        if ((dm ? stall_mem : stall_if) !== 1'b0) stall_ok = 0;
        break;
      end
      if ((dm ? stall_mem : stall_if) !== 1'b1) stall_ok = 0;
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] v;
    v = $urandom;
    v[11:2] = 10'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin : stim
    int          ack_at, en_at, dm_n;
    logic [9:0]  en_addr;
    logic        en_we;
    bit          stall_ok, got_if, renew, if_done, dm_done;
    logic [31:0] v;

    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    v = {OP_LW, 5'd5, 5'd3, 16'd4};
    env_mem[3] = v; ref_mem[3] = v;
    env_mem[5] = 32'h0; ref_mem[5] = 32'h0;
    v = {OP_SW, 5'd4, 5'd2, 16'd8};
    env_mem[7] = v; ref_mem[7] = v;

    reset_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_if_ack", 32'(if_ack), 32'd0);
    chk("reset_mem_en", 32'(mem_en), 32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    reset_n = 1'b1;
    step();

    // Single fetch of word 3.
    if_req = 1'b1; if_addr = 32'd12;
    wait_ack(1'b0, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    chk("t1_en_cycle", 32'(en_at), 32'd1);
    chk("t1_en_addr", 32'(en_addr), 32'd3);
    chk("t1_ack_cycle", 32'(ack_at), 32'd4);
    chk("t1_if_rdata", if_rdata, 32'h8ca30004);
    chk("t1_stall", 32'(stall_ok), 32'd1);
    step();
    if_req = 1'b0;
    step();

    // Store to word 5, then load it back.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'd20; dm_wdata = 32'hdeadbeef;
    wait_ack(1'b1, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    chk("t2_en_cycle", 32'(en_at), 32'd1);
    chk("t2_en_addr", 32'(en_addr), 32'd5);
    chk("t2_en_we", 32'(en_we), 32'd1);
    chk("t2_ack_cycle", 32'(ack_at), 32'd4);
    step();
    dm_we = 1'b0;
    wait_ack(1'b1, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    chk("t2_rb_ack_cycle", 32'(ack_at), 32'd4);
    chk("t2_rb_data", dm_rdata, 32'hdeadbeef);
    step();
    dm_req = 1'b0;
    step();

    // Simultaneous requests: data first, fetch granted in the data ack cycle.
    if_req = 1'b1; if_addr = 32'd12;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd20;
    wait_ack(1'b1, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    chk("t3_dm_ack_cycle", 32'(ack_at), 32'd4);
    chk("t3_dm_en_addr", 32'(en_addr), 32'd5);
    chk("t3_dm_rdata", dm_rdata, 32'hdeadbeef);
    step();
    dm_req = 1'b0;
    wait_ack(1'b0, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    chk("t3_if_en_cycle", 32'(en_at), 32'd0);
    chk("t3_if_ack_cycle", 32'(ack_at), 32'd3);
    chk("t3_if_rdata", if_rdata, 32'h8ca30004);
    step();
    if_req = 1'b0;
    step();

    // Data held continuously with fresh addresses; fetch must get through.
    if_req = 1'b1; if_addr = 32'd12;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd28;
    dm_n = 0; got_if = 0;
    for (int k = 0; k < 60 && !got_if; k++) begin
      @(negedge clock);
      if (k == 1) chk("t4_starve_one", 32'(u_dut.u_starve.cnt), 32'd1);
      renew = (dm_ack === 1'b1);
      if (renew) dm_n++;
      if (if_ack === 1'b1) begin
        got_if = 1;
        chk("t4_starve_clear", 32'(u_dut.u_starve.cnt), 32'd0);
      end
      step();
      if (renew) dm_addr = dm_addr + 32'd4;
    end
    chk("t4_if_served", 32'(got_if), 32'd1);
    chk("t4_dm_before_if", 32'(dm_n <= SMAX), 32'd1);
    if_req = 1'b0;
    wait_ack(1'b1, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    step();
    dm_req = 1'b0;
    step();

    // Reset during the wait cycle of a load; access restarts afterwards.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'd12;
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_no_ack", 32'(dm_ack), 32'd0);
    chk("t5_mem_en", 32'(mem_en), 32'd0);
    chk("t5_mem_addr", 32'(mem_addr), 32'd0);
    chk("t5_dm_rdata", dm_rdata, 32'd0);
    chk("t5_if_rdata", if_rdata, 32'd0);
    step();
    wait_ack(1'b1, 20, ack_at, en_at, en_addr, en_we, stall_ok);
    chk("t5_restart_ack", 32'(ack_at), 32'd3);
    chk("t5_restart_data", dm_rdata, 32'h8ca30004);
    step();
    dm_req = 1'b0;
    step();

    // Random requesters that hold each request until acked.
    if_done = 0; dm_done = 0;
    for (int n = 0; n < 3000; n++) begin
      step();
      reset_n = ($urandom_range(0, 199) != 0);
      if (if_done || !if_req) begin
        if_req  = ($urandom_range(0, 2) == 0) || (if_done && $urandom_range(0, 1) == 0);
        if_addr = rand_addr();
      end
      if (dm_done || !dm_req) begin
        dm_req   = ($urandom_range(0, 2) == 0) || (dm_done && $urandom_range(0, 1) == 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = rand_addr();
        dm_wdata = $urandom;
      end
      if_done = (if_ack === 1'b1);
      dm_done = (dm_ack === 1'b1);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
